montgomery_mul: RTL and testbench

//  Bit-serial (radix-2) Montgomery modular multiplier for the crypto library.
//  On a start pulse it computes y = a*b*R^-1 mod m, R = 2^(m_size+1), one

---
 rtl/montgomery_mul_if.sv | 20 ++
 rtl/montgomery_mul.sv | 65 ++++++
 tb/tb_montgomery_mul.sv | 128 ++++++++++++
 3 files changed

// File: rtl/montgomery_mul_if.sv
// montgomery_mul_if: start/operand/result bundle between a requester and the multiplier
interface montgomery_mul_if #(
    parameter int NBITS = 2048
);
    logic             enable_p;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic [NBITS-1:0] m;
    logic [NBITS-1:0] m_size;
    logic [NBITS-1:0] y;
    logic             done_irq_p;
    modport master (
        output enable_p, a, b, m, m_size,
        input  y, done_irq_p
    );
    modport slave (
        input  enable_p, a, b, m, m_size,
        output y, done_irq_p
    );
endinterface

// File: rtl/montgomery_mul.sv
// montgomery_mul: bit-serial radix-2 Montgomery multiplier, y = a*b*2^-(m_size+1) mod m
module montgomery_mul #(
    parameter int NBITS = 2048
) (
    input logic            clk,
    input logic            rst_n,
    montgomery_mul_if.slave bus
);
    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [NBITS-1:0] LAST = NBITS'(NBITS - 1);
    typedef enum logic [1:0] {IDLE, RUN, CORR} state_t;
    state_t           state;
    logic [NBITS+1:0] s, t0, t1, diff;
    logic [NBITS-1:0] a_sh, b_l, m_l, y_r;
    logic [IW-1:0]    cnt, last, ms_clamp;
    logic             done_r, ge;
    assign bus.y          = y_r;
    assign bus.done_irq_p = done_r;
    // a is consumed LSB first by shifting, so only bit 0 is ever examined
    always_comb begin
        ms_clamp = (bus.m_size > LAST) ? LAST[IW-1:0] : bus.m_size[IW-1:0];
        t0       = s + (a_sh[0] ? {2'b00, b_l} : '0);
        t1       = t0[0] ? t0 + {2'b00, m_l} : t0;
        ge       = s >= {2'b00, m_l};
        diff     = s - {2'b00, m_l};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            s      <= '0;
            a_sh   <= '0;
            b_l    <= '0;
            m_l    <= '0;
            cnt    <= '0;
            last   <= '0;
            y_r    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.enable_p) begin
                    a_sh  <= bus.a;
                    b_l   <= bus.b;
                    m_l   <= bus.m;
                    last  <= ms_clamp;
                    s     <= '0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    s     <= t1 >> 1;
                    a_sh  <= a_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == last) ? CORR : RUN;
                end
                CORR: begin
                    y_r    <= ge ? diff[NBITS-1:0] : s[NBITS-1:0];
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_montgomery_mul.sv
// tb_montgomery_mul: directed vectors with hand-computed Montgomery results
module tb_montgomery_mul;
    localparam int NB = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   pulses;
    always #5 clk = ~clk;
    montgomery_mul_if #(.NBITS(NB)) bus ();
    montgomery_mul #(.NBITS(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic drive(input logic [NB-1:0] a, input logic [NB-1:0] b,
                         input logic [NB-1:0] m, input logic [NB-1:0] ms);
        bus.a        = a;
        bus.b        = b;
        bus.m        = m;
        bus.m_size   = ms;
        bus.enable_p = 1'b1;
    endtask
    // returns at the falling edge just after the start edge, with operands scrambled
    task automatic start(input logic [NB-1:0] a, input logic [NB-1:0] b,
                         input logic [NB-1:0] m, input logic [NB-1:0] ms);
        @(negedge clk);
        drive(a, b, m, ms);
        @(negedge clk);
        bus.enable_p = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.m        = 32'd11;
        bus.m_size   = 32'd1;
    endtask
    task automatic wait_done(inout int cnt);
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.done_irq_p && cnt < 100);
    endtask
    task automatic count_pulses(input int cycles, output int p);
        p = 0;
        repeat (cycles) begin
            @(negedge clk);
            p += int'(bus.done_irq_p);
        end
    endtask
    initial begin
        bus.enable_p = 1'b0;
        bus.a = '0; bus.b = '0; bus.m = '0; bus.m_size = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_y", bus.y, 0);
        check("rst_done", bus.done_irq_p, 0);
        rst_n = 1'b1;
        count_pulses(10, pulses);
        check("idle_no_pulse", pulses, 0);
        // 5*7*16^-1 mod 13 = 3
        start(5, 7, 13, 3);
        n = 0; wait_done(n);
        check("t2_latency", n, 5);
        check("t2_y", bus.y, 3);
        @(negedge clk);
        check("t2_width", bus.done_irq_p, 0);
        check("t2_hold", bus.y, 3);
        start(3, 7, 13, 3);
        n = 0; wait_done(n);
        check("t3_identity", bus.y, 7);
        start(0, 7, 13, 3);
        n = 0; wait_done(n);
        check("t3_zero", bus.y, 0);
        // 5792*1229 mod 72639 = 72385, R = 2^18
        start(5792, 1229, 72639, 17);
        n = 0; wait_done(n);
        check("t4_latency", n, 19);
        check("t4_range", longint'(bus.y < 72639), 1);
        check("t4_mont", (longint'(bus.y) * 262144) % 72639, 72385);
        count_pulses(5, pulses);
        check("t4_no_extra", pulses, 0);
        check("t4_stable", (longint'(bus.y) * 262144) % 72639, 72385);
        // restart attempt in RUN is ignored
        start(5, 7, 13, 3);
        n = 0;
        @(negedge clk); n++;
        drive(3, 7, 13, 3);
        @(negedge clk); n++;
        bus.enable_p = 1'b0;
        wait_done(n);
        check("t5_latency", n, 5);
        check("t5_y", bus.y, 3);
        // back-to-back start in the done cycle
        drive(3, 7, 13, 3);
        @(negedge clk);
        bus.enable_p = 1'b0;
        check("t5_b2b_width", bus.done_irq_p, 0);
        n = 0; wait_done(n);
        check("t5_b2b_latency", n, 5);
        check("t5_b2b_y", bus.y, 7);
        // reset mid-RUN
        start(5, 7, 13, 3);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_y", bus.y, 0);
        check("t6_rst_done", bus.done_irq_p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_pulses(10, pulses);
        check("t6_no_pulse", pulses, 0);
        start(3, 7, 13, 3);
        n = 0; wait_done(n);
        check("t6_latency", n, 5);
        check("t6_y", bus.y, 7);
        // m_size beyond the width clamps to NB-1: 32 iterations, R = 2^32
        start(5, 7, 13, 40);
        n = 0; wait_done(n);
        check("clamp_latency", n, 33);
        check("clamp_range", longint'(bus.y < 13), 1);
        check("clamp_mont", (longint'(bus.y) << 32) % 13, 9);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
